// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder
// Buffers a fixed-length message and applies SHA-256 padding to it. Each
// padded 512-bit block is handed to the multi-cycle round core together with
// the current chaining value. The final chaining value is returned as the
// digest over a valid/ready handshake.
`timescale 1ns/1ps
module sha256_block_feeder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              core_start,
  output logic [15:0][31:0] core_message,
  output logic [7:0][31:0]  core_hin,
  input  logic [7:0][31:0]  core_hout,
  input  logic              core_done,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic [7:0][31:0]  digest
);

  // Number of padded blocks: message words, the 0x80 marker word and the
  // two length words must all fit.
  localparam int NB = (NUM_OF_WORDS + 18) / 16;
  localparam int AW = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;

  localparam logic [31:0] BIT_LEN    = 32'(32 * NUM_OF_WORDS);
  localparam logic [6:0]  LAST_WORD  = 7'(NUM_OF_WORDS - 1);
  localparam logic [6:0]  PAD_IDX    = 7'(NUM_OF_WORDS);
  localparam logic [6:0]  LEN_IDX    = 7'(16 * NB - 1);
  localparam logic [2:0]  LAST_BLOCK = 3'(NB - 1);

  // SHA-256 initial hash value; element k is Hk.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    LOAD,
    BUILD,
    START,
    WAIT,
    OUT
  } state_t;

  state_t state;
  state_t next_state;

  logic [6:0]       count;
  logic [2:0]       blk;
  logic [31:0]      msg_buf [NUM_OF_WORDS];
  logic [7:0][31:0] h;
  logic [15:0][31:0] block_words;
  logic [6:0]       pad_idx;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the handshake and start strobes, all pure
  // functions of the current state and inputs.
  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    core_start   = 1'b0;
    digest_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (count == LAST_WORD)) begin
          next_state = BUILD;
        end
      end
      BUILD: begin
        next_state = START;
      end
      START: begin
        core_start = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          next_state = (blk < LAST_BLOCK) ? BUILD : OUT;
        end
      end
      OUT: begin
        digest_valid = 1'b1;
        if (digest_ready) begin
          next_state = LOAD;
        end
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  // Padded view of the current block: message words, then the 0x80 marker,
  // zero fill, and the bit length in the very last word of the last block.
  always_comb begin
    block_words = '0;
    pad_idx     = '0;
    for (int j = 0; j < 16; j++) begin
      pad_idx = {blk, 4'(j)};
      if (pad_idx < PAD_IDX) begin
        block_words[j] = msg_buf[pad_idx[AW-1:0]];
      end else if (pad_idx == PAD_IDX) begin
        block_words[j] = 32'h8000_0000;
      end else if (pad_idx == LEN_IDX) begin
        block_words[j] = BIT_LEN;
      end
    end
  end

  // Message capture, block presentation, chaining update and digest latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      blk          <= '0;
      h            <= IV;
      core_message <= '0;
      core_hin     <= '0;
      digest       <= '0;
      for (int i = 0; i < NUM_OF_WORDS; i++) begin
        msg_buf[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          blk <= '0;
          if (in_valid) begin
            msg_buf[count[AW-1:0]] <= in_data;
            count                  <= count + 7'd1;
          end
        end
        BUILD: begin
          core_message <= block_words;
          core_hin     <= {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
        end
        WAIT: begin
          if (core_done) begin
            h <= core_hout;
            if (blk < LAST_BLOCK) begin
              blk <= blk + 3'd1;
            end else begin
              digest <= core_hout;
            end
          end
        end
        OUT: begin
          if (digest_ready) begin
            h     <= IV;
            count <= '0;
            blk   <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// tb_sha256_block_feeder
// Three feeders (N=20, N=13, N=14) each driven by a stub round core. The stub
// either returns k+1 for Hk or mixes chaining value and block words, so the
// expected digest follows from the hand-written padding and the IV.
`timescale 1ns/1ps
module tb_sha256_block_feeder;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  logic clk = 1'b0;
  logic reset_n;

  logic              in_valid_a     [3];
  logic [31:0]       in_data_a      [3];
  logic              in_ready_a     [3];
  logic              core_start_a   [3];
  logic [15:0][31:0] core_message_a [3];
  logic [7:0][31:0]  core_hin_a     [3];
  logic [7:0][31:0]  core_hout_a    [3] = '{default: '0};
  logic              core_done_r    [3] = '{default: 1'b0};
  logic              extra_done     [3];
  logic              done_in        [3];
  logic              digest_valid_a [3];
  logic              digest_ready_a [3];
  logic [7:0][31:0]  digest_a       [3];

  int lat         [3] = '{default: 0};
  int start_cnt   [3] = '{default: 0};
  int overlap_err [3] = '{default: 0};
  bit stub_mode;

  logic [15:0][31:0] cap_msg [3][32];
  logic [7:0][31:0]  cap_hin [3][32];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NW = (g == 0) ? 20 : ((g == 1) ? 13 : 14);
    assign done_in[g] = core_done_r[g] | extra_done[g];
    sha256_block_feeder #(.NUM_OF_WORDS(NW)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid_a[g]),
      .in_ready     (in_ready_a[g]),
      .in_data      (in_data_a[g]),
      .core_start   (core_start_a[g]),
      .core_message (core_message_a[g]),
      .core_hin     (core_hin_a[g]),
      .core_hout    (core_hout_a[g]),
      .core_done    (done_in[g]),
      .digest_valid (digest_valid_a[g]),
      .digest_ready (digest_ready_a[g]),
      .digest       (digest_a[g])
    );
  end

  function automatic logic [7:0][31:0] revH(input logic [7:0][31:0] hv);
    for (int k = 0; k < 8; k++) revH[7-k] = hv[k];
  endfunction

  function automatic logic [7:0][31:0] stubF(input logic [7:0][31:0] hin,
                                             input logic [15:0][31:0] msg,
                                             input bit mode);
    for (int k = 0; k < 8; k++) begin
      if (mode) stubF[k] = (hin[7-k] ^ msg[2*k]) + msg[2*k+1] + 32'(k);
      else      stubF[k] = 32'(k + 1);
    end
  endfunction

  function automatic logic [15:0][31:0] expBlock(input int n, input int b,
                                                 input logic [31:0] base);
    int nb = (n + 18) / 16;
    int p;
    expBlock = '0;
    for (int j = 0; j < 16; j++) begin
      p = 16 * b + j;
      if (p < n)               expBlock[j] = base + 32'(p);
      else if (p == n)         expBlock[j] = 32'h8000_0000;
      else if (p == 16*nb - 1) expBlock[j] = 32'(32 * n);
    end
  endfunction

  function automatic logic [7:0][31:0] modelDigest(input int n, input logic [31:0] base,
                                                   input bit mode);
    int nb = (n + 18) / 16;
    modelDigest = IV;
    for (int b = 0; b < nb; b++) modelDigest = stubF(revH(modelDigest), expBlock(n, b, base), mode);
  endfunction

  // Stub round core: latches each start, answers three cycles later.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      core_done_r[g] <= 1'b0;
      if (core_start_a[g]) begin
        if (lat[g] != 0) overlap_err[g] <= overlap_err[g] + 1;
        if (start_cnt[g] < 32) begin
          cap_msg[g][start_cnt[g]] <= core_message_a[g];
          cap_hin[g][start_cnt[g]] <= core_hin_a[g];
        end
        start_cnt[g] <= start_cnt[g] + 1;
        lat[g]       <= 3;
      end else if (lat[g] != 0) begin
        lat[g] <= lat[g] - 1;
        if (lat[g] == 1) begin
          core_done_r[g] <= 1'b1;
          core_hout_a[g] <= stubF(core_hin_a[g], core_message_a[g], stub_mode);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs,
                             input logic [511:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feeds words base..base+n-1; returns at the negedge after the last transfer.
  task automatic applyStimulus(input int g, input int n, input logic [31:0] base,
                               input bit stall);
    int  i = 0;
    int  guard = 0;
    bit  v;
    bit  rdy;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      rdy = in_ready_a[g];
      v   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_a[g] = v;
      in_data_a[g]  = v ? base + 32'(i) : 32'hDEAD_BEEF;
      @(posedge clk);
      if (v && rdy) i++;
      guard++;
    end
    if (i != n) checkOutput("input_timeout", 32'(i), 32'(n));
    @(negedge clk);
    in_valid_a[g] = 1'b0;
  endtask

  task automatic waitDigest(input int g, input int target, output logic [7:0][31:0] dig);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done_in[g] && start_cnt[g] == target) seen = 1'b1;
    end
    checkOutput("final_done_seen", seen, 1);
    @(negedge clk);
    checkOutput("digest_valid_rise", digest_valid_a[g], 1);
    dig = digest_a[g];
  endtask

  task automatic consumeDigest(input int g);
    digest_ready_a[g] = 1'b1;
    @(negedge clk);
    digest_ready_a[g] = 1'b0;
    checkOutput("in_ready_after_hs", in_ready_a[g], 1);
    checkOutput("dvalid_after_hs", digest_valid_a[g], 0);
  endtask

  initial begin
    logic [7:0][31:0]  dig;
    logic [7:0][31:0]  exp_h;
    logic [15:0][31:0] hand_blk;
    int base;
    int cyc;
    bit bad;

    reset_n   = 1'b0;
    stub_mode = 1'b1;
    for (int g = 0; g < 3; g++) begin
      in_valid_a[g]     = 1'b0;
      in_data_a[g]      = '0;
      digest_ready_a[g] = 1'b0;
      extra_done[g]     = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready_a[0], 1);
    checkOutput("rst_core_start", core_start_a[0], 0);
    checkOutput("rst_core_message", core_message_a[0], 0);
    checkOutput("rst_core_hin", core_hin_a[0], 0);
    checkOutput("rst_digest_valid", digest_valid_a[0], 0);
    checkOutput("rst_digest", digest_a[0], 0);
    reset_n = 1'b1;

    // N=20, back-to-back words 0..19
    base = start_cnt[0];
    applyStimulus(0, 20, 32'h0, 1'b0);
    checkOutput("build_no_start", core_start_a[0], 0);
    checkOutput("build_in_ready", in_ready_a[0], 0);
    @(negedge clk);
    checkOutput("start_pulse", core_start_a[0], 1);
    waitDigest(0, base + 2, dig);
    checkOutput("n20_starts", 32'(start_cnt[0] - base), 2);
    checkOutput("n20_blk0", cap_msg[0][base], expBlock(20, 0, 32'h0));
    checkOutput("n20_blk1", cap_msg[0][base+1], expBlock(20, 1, 32'h0));
    checkOutput("n20_b1_w3", cap_msg[0][base+1][3], 32'h13);
    checkOutput("n20_b1_w4", cap_msg[0][base+1][4], 32'h8000_0000);
    checkOutput("n20_b1_w15", cap_msg[0][base+1][15], 32'h280);
    checkOutput("n20_hin_blk0", cap_hin[0][base], revH(IV));
    checkOutput("n20_digest", dig, modelDigest(20, 32'h0, 1'b1));

    // digest back-pressure for 50 cycles
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!digest_valid_a[0] || digest_a[0] !== dig || in_ready_a[0]) bad = 1'b1;
    end
    checkOutput("backpressure_hold", bad, 0);
    consumeDigest(0);

    // chaining with constant stub output
    stub_mode = 1'b0;
    base = start_cnt[0];
    applyStimulus(0, 20, 32'h0, 1'b0);
    waitDigest(0, base + 2, dig);
    for (int k = 0; k < 8; k++) exp_h[7-k] = 32'(k + 1);
    checkOutput("chain_hin_blk0_h0", cap_hin[0][base][7], 32'h6a09e667);
    checkOutput("chain_hin_blk1", cap_hin[0][base+1], exp_h);
    checkOutput("chain_digest", dig, revH(exp_h));
    consumeDigest(0);

    // random input stalls
    stub_mode = 1'b1;
    base = start_cnt[0];
    applyStimulus(0, 20, 32'h0, 1'b1);
    waitDigest(0, base + 2, dig);
    checkOutput("stall_blk0", cap_msg[0][base], expBlock(20, 0, 32'h0));
    checkOutput("stall_blk1", cap_msg[0][base+1], expBlock(20, 1, 32'h0));
    checkOutput("stall_digest", dig, modelDigest(20, 32'h0, 1'b1));
    consumeDigest(0);

    // reset while waiting on block 1
    base = start_cnt[0];
    applyStimulus(0, 20, 32'h0, 1'b0);
    cyc = 0;
    while (start_cnt[0] != base + 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reach_blk1_wait", 32'(start_cnt[0] - base), 2);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", in_ready_a[0], 1);
    checkOutput("mid_rst_core_start", core_start_a[0], 0);
    checkOutput("mid_rst_core_message", core_message_a[0], 0);
    checkOutput("mid_rst_core_hin", core_hin_a[0], 0);
    checkOutput("mid_rst_digest_valid", digest_valid_a[0], 0);
    checkOutput("mid_rst_digest", digest_a[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    extra_done[0] = 1'b1;
    @(negedge clk);
    extra_done[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("stale_done_in_ready", in_ready_a[0], 1);
    checkOutput("stale_done_dvalid", digest_valid_a[0], 0);
    checkOutput("stale_done_no_start", 32'(start_cnt[0] - base), 2);
    checkOutput("stale_done_msg", core_message_a[0], 0);
    base = start_cnt[0];
    applyStimulus(0, 20, 32'h1000, 1'b0);
    waitDigest(0, base + 2, dig);
    checkOutput("post_rst_digest", dig, modelDigest(20, 32'h1000, 1'b1));
    consumeDigest(0);

    // N=13: single block
    base = start_cnt[1];
    applyStimulus(1, 13, 32'h500, 1'b0);
    waitDigest(1, base + 1, dig);
    checkOutput("n13_starts", 32'(start_cnt[1] - base), 1);
    checkOutput("n13_w12", cap_msg[1][base][12], 32'h50C);
    checkOutput("n13_w13", cap_msg[1][base][13], 32'h8000_0000);
    checkOutput("n13_w14", cap_msg[1][base][14], 32'h0);
    checkOutput("n13_w15", cap_msg[1][base][15], 32'h1A0);
    checkOutput("n13_digest", dig, modelDigest(13, 32'h500, 1'b1));
    consumeDigest(1);

    // N=14: marker fills block 0, length alone in block 1
    base = start_cnt[2];
    applyStimulus(2, 14, 32'h700, 1'b0);
    waitDigest(2, base + 2, dig);
    checkOutput("n14_starts", 32'(start_cnt[2] - base), 2);
    checkOutput("n14_b0_w14", cap_msg[2][base][14], 32'h8000_0000);
    checkOutput("n14_b0_w15", cap_msg[2][base][15], 32'h0);
    hand_blk     = '0;
    hand_blk[15] = 32'h1C0;
    checkOutput("n14_blk1", cap_msg[2][base+1], hand_blk);
    checkOutput("n14_digest", dig, modelDigest(14, 32'h700, 1'b1));
    consumeDigest(2);

    for (int g = 0; g < 3; g++) checkOutput("start_while_busy", 32'(overlap_err[g]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
